// File: rtl/svn_pkg.sv
// Shared constants and types for the seven-segment digit scanner.
package svn_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic       AN_OFF     = 1'b1;
    localparam logic       DP_OFF     = 1'b1;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } slot_state_t;

    // Digit-index width, never narrower than one bit.
    function automatic int idx_w(input int n_digits);
        return ($clog2(n_digits) < 1) ? 1 : $clog2(n_digits);
    endfunction

endpackage

// File: rtl/svn_slot_timer.sv
// Slot counter and digit index for the scanner; flags slot/frame wrap and the dead-time gap.
module svn_slot_timer
    import svn_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SLOT_CYC = 100000,
    parameter int GAP_CYC  = 2,
    localparam int CNT_W   = $clog2(SLOT_CYC),
    localparam int IDX_W   = idx_w(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             slot_wrap,
    output logic             frame_wrap,
    output logic             in_gap
);

    logic [CNT_W-1:0] cnt_p0;
    logic [IDX_W-1:0] idx_p0;

    assign slot_wrap  = (cnt_p0 == CNT_W'(SLOT_CYC - 1));
    assign frame_wrap = slot_wrap && (idx_p0 == IDX_W'(N_DIGITS - 1));
    assign in_gap     = (cnt_p0 < CNT_W'(GAP_CYC));
    assign idx        = idx_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else if (slot_wrap) begin
            cnt_p0 <= '0;
            idx_p0 <= (idx_p0 == IDX_W'(N_DIGITS - 1)) ? '0 : idx_p0 + IDX_W'(1);
        end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

endmodule

// File: rtl/svn_scan_mux.sv
// Time-multiplexed hex digit scanner feeding a seven-segment decoder, with
// frame-synchronous shadow updates, leading-zero blanking and inter-digit dead time.
module svn_scan_mux
    import svn_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SLOT_CYC = 100000,
    parameter int GAP_CYC  = 2,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [3:0]            nibble,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int IDX_W = idx_w(N_DIGITS);

    logic [IDX_W-1:0] idx_p0;
    logic             slot_wrap_p0;
    logic             frame_wrap_p0;
    logic             in_gap_p0;
    logic             xfer_p0;

    svn_slot_timer #(
        .N_DIGITS (N_DIGITS),
        .SLOT_CYC (SLOT_CYC),
        .GAP_CYC  (GAP_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx_p0),
        .slot_wrap  (slot_wrap_p0),
        .frame_wrap (frame_wrap_p0),
        .in_gap     (in_gap_p0)
    );

    assign xfer_p0 = slot_wrap_p0 && frame_wrap_p0;

    logic [4*N_DIGITS-1:0] sh_value, act_value;
    logic [N_DIGITS-1:0]   sh_dp, act_dp;
    logic [N_DIGITS-1:0]   sh_en, act_en;
    logic                  pending_r;

    // A load on the frame boundary lands in the shadow after the old shadow
    // has moved to active, so it waits a full frame and pending stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_en     <= '1;
            act_value <= '0;
            act_dp    <= '0;
            act_en    <= '1;
            pending_r <= 1'b0;
        end else begin
            if (xfer_p0 && pending_r) begin
                act_value <= sh_value;
                act_dp    <= sh_dp;
                act_en    <= sh_en;
            end
            if (load) begin
                sh_value  <= value;
                sh_dp     <= dp_mask;
                sh_en     <= digit_en;
                pending_r <= 1'b1;
            end else if (xfer_p0) begin
                pending_r <= 1'b0;
            end
        end
    end

    slot_state_t           state_p0;
    logic [N_DIGITS-1:0]   lz_p0;
    logic                  zero_above;
    logic [3:0]            cur_digit_p0;
    logic                  cur_dp_p0;
    logic                  cur_en_p0;
    logic                  cur_lz_p0;
    logic [N_DIGITS-1:0]   an_d;
    logic [3:0]            nib_d;
    logic                  dp_d;

    assign state_p0 = in_gap_p0 ? GAP : SHOW;

    always_comb begin
        zero_above = 1'b1;
        lz_p0      = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
            lz_p0[i]   = (LZ_BLANK != 0) && (i != 0) && zero_above;
        end
    end

    always_comb begin
        cur_digit_p0 = BLANK_CODE;
        cur_dp_p0    = 1'b0;
        cur_en_p0    = 1'b0;
        cur_lz_p0    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_p0 == IDX_W'(i)) begin
                cur_digit_p0 = act_value[4*i +: 4];
                cur_dp_p0    = act_dp[i];
                cur_en_p0    = act_en[i];
                cur_lz_p0    = lz_p0[i];
            end
        end
    end

    // A blanked digit keeps its anode driven so brightness stays uniform;
    // only a disabled digit goes fully dark.
    always_comb begin
        an_d  = {N_DIGITS{AN_OFF}};
        nib_d = BLANK_CODE;
        dp_d  = DP_OFF;
        if (state_p0 == SHOW && cur_en_p0) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx_p0 == IDX_W'(i)) ? ~AN_OFF : AN_OFF;
            end
            nib_d = cur_lz_p0 ? BLANK_CODE : cur_digit_p0;
            dp_d  = ~cur_dp_p0;
        end
    end

    // ---- p1: registered outputs, one cycle behind cnt/idx ----
    logic [N_DIGITS-1:0] an_n_p1;
    logic [3:0]          nibble_p1;
    logic                dp_n_p1;
    logic                frame_done_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_p1       <= {N_DIGITS{AN_OFF}};
            nibble_p1     <= BLANK_CODE;
            dp_n_p1       <= DP_OFF;
            frame_done_p1 <= 1'b0;
        end else begin
            an_n_p1       <= an_d;
            nibble_p1     <= nib_d;
            dp_n_p1       <= dp_d;
            frame_done_p1 <= xfer_p0;
        end
    end

    assign an_n       = an_n_p1;
    assign nibble     = nibble_p1;
    assign dp_n       = dp_n_p1;
    assign frame_done = frame_done_p1;
    assign pending    = pending_r;

endmodule

// File: tb/tb_svn_scan_mux.sv
// Directed bench for svn_scan_mux at N_DIGITS=4, SLOT_CYC=8, GAP_CYC=2.
module tb_svn_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_en = 4'hF;

    logic [3:0] nib_a, an_a, nib_b, an_b;
    logic       dp_a, pend_a, fd_a, dp_b, pend_b, fd_b;

    int n_cmp = 0;
    int n_fail = 0;
    int tick_count = 0;

    always #5 clk = ~clk;

    svn_scan_mux #(.N_DIGITS(4), .SLOT_CYC(8), .GAP_CYC(2), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .digit_en(digit_en), .nibble(nib_a), .dp_n(dp_a), .an_n(an_a),
        .pending(pend_a), .frame_done(fd_a)
    );

    svn_scan_mux #(.N_DIGITS(4), .SLOT_CYC(8), .GAP_CYC(2), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .digit_en(digit_en), .nibble(nib_b), .dp_n(dp_b), .an_n(an_b),
        .pending(pend_b), .frame_done(fd_b)
    );

    // After each tick the outputs describe cycle label tick_count-1 since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_count++;
    endtask

    task automatic sync_frame();
        while (tick_count % 32 != 0) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        value = v; dp_mask = dp; digit_en = en; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // exp_nib/exp_dp_n are per-digit hand values; exp_dark marks digits whose anode stays off.
    task automatic check_frame(input string name, input logic use_b, input logic [15:0] exp_nib,
                               input logic [3:0] exp_dp_n, input logic [3:0] exp_dark,
                               input logic exp_pend, input logic exp_pend_last);
        logic [10:0] got, exp;
        logic [3:0]  e_an, e_nib;
        logic        e_dp, e_fd, e_p;
        int k, c, d;
        for (int s = 0; s < 32; s++) begin
            tick();
            k = tick_count - 1;
            c = k % 8;
            d = (k / 8) % 4;
            if (c < 2) begin
                e_an = 4'hF; e_nib = 4'hF; e_dp = 1'b1;
            end else begin
                e_an  = exp_dark[d] ? 4'hF : ~(4'b0001 << d);
                e_nib = exp_nib[4*d +: 4];
                e_dp  = exp_dp_n[d];
            end
            e_fd = (c == 7 && d == 3);
            e_p  = (c == 7 && d == 3) ? exp_pend_last : exp_pend;
            exp  = {e_an, e_nib, e_dp, e_fd, e_p};
            got  = use_b ? {an_b, nib_b, dp_b, fd_b, pend_b} : {an_a, nib_a, dp_a, fd_a, pend_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {an,nib,dp,fd,pend} got %b required %b", name, k, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({an_a, nib_a, dp_a, fd_a, pend_a} !== {4'hF, 4'hF, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", {an_a, nib_a, dp_a, fd_a, pend_a}, 11'b11111111100);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_count = 0;
        check_frame("idle_frame0", 1'b0, 16'hFFF0, 4'hF, 4'h0, 1'b0, 1'b0);
        check_frame("idle_frame1", 1'b0, 16'hFFF0, 4'hF, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_update();
        int k;
        sync_frame();
        repeat (10) tick();
        do_load(16'h12A4, 4'b0010, 4'hF);
        n_cmp++;
        if (pend_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_set: got %b required 1", pend_a);
        end
        while (tick_count % 32 != 0) begin
            tick();
            k = tick_count - 1;
            n_cmp++;
            if ({pend_a, fd_a} !== ((k % 32 == 31) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL pending_hold cycle %0d: {pend,fd} got %b required %b", k, {pend_a, fd_a},
                         (k % 32 == 31) ? 2'b01 : 2'b10);
            end
        end
        check_frame("value_12A4", 1'b0, 16'h12A4, 4'b1101, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_lz_blank();
        sync_frame();
        do_load(16'h0070, 4'b0000, 4'hF);
        sync_frame();
        check_frame("lz_on_0070", 1'b0, 16'hFF70, 4'hF, 4'h0, 1'b0, 1'b0);
        check_frame("lz_off_0070", 1'b1, 16'h0070, 4'hF, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_digit_en();
        sync_frame();
        do_load(16'h8888, 4'b0000, 4'b1011);
        sync_frame();
        check_frame("digit_en_1011", 1'b0, 16'h8F88, 4'hF, 4'b0100, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sync_frame();
        repeat (4) tick();
        do_load(16'h1111, 4'b0000, 4'hF);
        while (tick_count % 32 != 31) tick();
        do_load(16'h5555, 4'b0000, 4'hF);
        n_cmp++;
        if ({pend_a, fd_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_on_boundary: {pend,fd} got %b required 11", {pend_a, fd_a});
        end
        check_frame("frame_1111", 1'b0, 16'h1111, 4'hF, 4'h0, 1'b1, 1'b0);
        check_frame("frame_5555", 1'b0, 16'h5555, 4'hF, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        sync_frame();
        repeat (2) tick();
        do_load(16'h3333, 4'b1111, 4'hF);
        while (tick_count % 32 != 21) tick();
        n_cmp++;
        if ({an_a, nib_a} !== {4'b1011, 4'h5}) begin
            n_fail++;
            $display("FAIL pre_reset_digit2: {an,nib} got %b required %b", {an_a, nib_a}, {4'b1011, 4'h5});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({an_a, nib_a, dp_a, fd_a, pend_a} !== {4'hF, 4'hF, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b required %b", {an_a, nib_a, dp_a, fd_a, pend_a}, 11'b11111111100);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick_count = 0;
        check_frame("after_reset", 1'b0, 16'hFFF0, 4'hF, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_update();
        test_lz_blank();
        test_digit_en();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/svn_scan_mux.md
Name: svn_scan_mux

Overview:
- Time-multiplexed digit scanner that sits directly upstream of the seven-segment decoder.
- Holds an N-digit hex value and rotates through the digits, one slot per digit.
- Each cycle it presents the current digit's 4-bit code and active-low decimal point to the decoder, and drives the matching active-low anode.
- Provides tear-free frame-synchronous updates, leading-zero blanking and an anti-ghosting dead time between digits.

Parameters:
- N_DIGITS, 4: number of multiplexed digits (2..8).
- SLOT_CYC, 100000: clock cycles per digit slot (≥ 4).
- GAP_CYC, 2: all-anodes-off cycles at the start of each slot (0 ≤ GAP_CYC < SLOT_CYC).
- LZ_BLANK, 1: 1 enables leading-zero blanking.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- load, in, 1: single-cycle strobe that captures value/dp_mask/digit_en into the shadow registers.
- value, in, 4*N_DIGITS: hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
- dp_mask, in, N_DIGITS: 1 lights the decimal point of digit i.
- digit_en, in, N_DIGITS: 0 forces digit i dark.
- nibble, out, 4: code to the decoder; 4'hF means blank (the decoder renders 4'hF as all segments off).
- dp_n, out, 1: active-low decimal point to the decoder DP path.
- an_n, out, N_DIGITS: active-low anode enables, at most one low at a time.
- pending, out, 1: shadow data not yet applied to the display.
- frame_done, out, 1: one-cycle pulse on the last cycle of slot N_DIGITS-1.

Behaviour:
- Reset (async assert, sync release):
  - an_n all 1, nibble 4'hF, dp_n 1, pending 0, frame_done 0.
  - Slot counter 0, digit index 0.
  - Active and shadow registers 0; digit_en copies reset to all 1.
- Slot counter runs 0..SLOT_CYC-1 and wraps. On wrap, the digit index increments mod N_DIGITS.
- Counter and index are in the first cycle after reset release are cnt=0, idx=0.
- Two-state FSM per slot:
  - GAP while cnt < GAP_CYC; SHOW otherwise.
  - GAP: an_n all 1, nibble 4'hF, dp_n 1.
  - SHOW with idx=i:
    - an_n[i]=0, all other bits 1.
    - nibble = active digit i, or 4'hF if blanked.
    - dp_n = ~active_dp[i].
  - Blanked means digit_en[i]=0, or LZ blanking applies.
  - A blanked digit keeps its anode low and shows 4'hF, so brightness stays uniform. Exception: digit_en[i]=0 also holds an_n[i]=1 and dp_n=1.
- Leading-zero blanking:
  - Applies when LZ_BLANK=1, i>0, and active digits i..N_DIGITS-1 are all 4'h0.
  - Digit 0 is never LZ-blanked.
  - The decimal point stays lit on an LZ-blanked digit if its dp_mask bit is set.
- Output registration: all outputs are registered. They reflect the cnt/idx of the previous cycle, giving a fixed 1-cycle latency.
- Update path:
  - load=1 copies inputs into the shadow registers and sets pending=1.
  - Multiple loads before transfer: the last one wins.
- Transfer:
  - Occurs in the cycle where idx wraps N_DIGITS-1→0 (cnt wraps), i.e. the frame_done cycle.
  - Shadow is copied to active only if pending=1; pending then clears.
  - The display therefore never mixes two values within a frame.
- load coinciding with the transfer cycle: the transfer uses the shadow contents before that load. The new data enters the shadow, pending stays 1, and it is applied at the next frame boundary.
- frame_done is asserted (registered) for exactly one cycle per frame, every N_DIGITS*SLOT_CYC cycles.
- Reset mid-frame: returns immediately to the reset state. Pending data is discarded.
- Counter width is $clog2(SLOT_CYC); index width is $clog2(N_DIGITS), minimum 1. No truncation warnings allowed.

Decomposition:
- Shared package svn_pkg:
  - BLANK_CODE = 4'hF.
  - Active-low constants AN_OFF / DP_OFF = 1.
  - Slot-state enum {GAP, SHOW}.
- One natural sub-module: svn_slot_timer. It contains the slot counter and digit index, and emits slot_wrap, frame_wrap and in_gap.

Test Plan (N_DIGITS=4, SLOT_CYC=8, GAP_CYC=2, LZ_BLANK=1):
1. Reset release with no load → every slot: 2 cycles all-off, then an_n=1110/1101/1011/0111 in turn. nibble=0 on digit 0, 4'hF on digits 1–3, dp_n=1. frame_done pulses every 32 cycles.
2. load value=16'h12A4, dp_mask=4'b0010, digit_en=4'hF mid-frame → pending=1 until the next frame_done, then clears. The next frame shows 4,A,2,1, with dp_n=0 only during digit 1.
3. load value=16'h0070 → digit 0 shows 0, digit 1 shows 7, digits 2–3 nibble=4'hF (LZ). Repeat with LZ_BLANK=0 → 0,7,0,0.
4. digit_en=4'b1011 with value=16'h8888 → an_n[2] stays 1 for the entire slot 2; other digits show 8.
5. load asserted on the frame_done cycle with value=16'h5555 while the shadow holds 16'h1111 → the next frame shows 1111, the following frame shows 5555, and pending is 1 across the intervening frame.
6. rst_n asserted mid-SHOW of digit 2 → an_n=1111 and nibble=4'hF in the same cycle (async). After release, scanning restarts at digit 0, and active is 0 with pending=0.
